// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned MAX_READ_LATENCY = 4;

    // One response pipeline entry.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the sized data memory: store merge, load extract
// with sign/zero extension, misalign and reserved-size detection.
// Lane order is big-endian within the word: byte offset 0 is bits [31:24].
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        rsvd
);

    size_t       sz;
    logic [4:0]  shamt;
    logic [3:0]  mask;
    logic [31:0] wpos;
    logic [31:0] shifted;

    assign sz = size_t'(size);

    // Lane selection, store merge and load extension from size and offset.
    always_comb begin
        shamt    = '0;
        mask     = '0;
        wpos     = '0;
        rdata    = '0;
        misalign = 1'b0;
        rsvd     = 1'b0;
        merged   = rword;

        case (sz)
            SZ_BYTE: begin
                shamt = {2'd3 - offset, 3'b000};
                mask  = 4'b0001 << (2'd3 - offset);
                wpos  = {24'h0, wdata[7:0]} << shamt;
            end
            SZ_HALF: begin
                shamt    = offset[1] ? 5'd0 : 5'd16;
                mask     = offset[1] ? 4'b0011 : 4'b1100;
                wpos     = {16'h0, wdata[15:0]} << shamt;
                misalign = offset[0];
            end
            SZ_WORD: begin
                shamt    = 5'd0;
                mask     = 4'b1111;
                wpos     = wdata;
                misalign = (offset != 2'b00);
            end
            default: begin
                rsvd = 1'b1;
            end
        endcase

        shifted = rword >> shamt;

        case (sz)
            SZ_BYTE: rdata = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: rdata = shifted;
            default: rdata = '0;
        endcase

        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = wpos[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_sized.sv
// Sized single-port data memory: post-reset clear FSM, valid/ready request
// port, byte/half/word access with error checks and a fixed-latency
// in-order response pipeline.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 64,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

    if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY) || (DEPTH_WORDS < 2)) begin : g_param_check
        $error("dmem_sized: illegal READ_LATENCY or DEPTH_WORDS");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  clr_idx;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] word_full;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              accept;
    logic              err;
    logic              misalign;
    logic              rsvd;
    logic [31:0]       rword;
    logic [31:0]       merged;
    logic [31:0]       ext;

    resp_t             stage_in;
    resp_t             pipe [READ_LATENCY];

    assign word_full = req_addr[ADDR_W-1:2];
    assign idx       = word_full[IDX_W-1:0];
    assign oor       = (word_full >= DEPTH_LIM);
    assign rword     = oor ? '0 : mem[idx];
    assign accept    = req_valid && req_ready;
    assign err       = oor || misalign || rsvd;

    dmem_lane_align u_align (
        .size        (req_size),
        .offset      (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (rword),
        .merged      (merged),
        .rdata       (ext),
        .misalign    (misalign),
        .rsvd        (rsvd)
    );

    // Clear/run next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // State register and clear-walk counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // Array write port: clearing walk in CLEAR, legal stores in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (accept && req_we && !err) begin
                mem[idx] <= merged;
            end
        end
    end

    // Response entry formed at the acceptance edge.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.err   = accept && err;
        if (accept && !req_we && !err) begin
            stage_in.data = ext;
        end
    end

    // Fixed-latency response shift register; reset drops in-flight entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign resp_valid = pipe[READ_LATENCY-1].valid;
    assign resp_err   = pipe[READ_LATENCY-1].err;
    assign resp_rdata = pipe[READ_LATENCY-1].data;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: the driver queues the expected response
// for every accepted request, a negedge monitor checks data, error and timing.
module tb_dmem_sized;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_done;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          id;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   id_ctr     = 0;
    int   unexpected = 0;

    dmem_sized #(
        .DEPTH_WORDS  (DEPTH),
        .ADDR_W       (32),
        .READ_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .init_done    (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (resp_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                unexpected++;
                $display("FAIL unexpected_resp got rdata=%h err=%b at cyc=%0d expected no response",
                         resp_rdata, resp_err, cyc);
            end else begin
                e = q.pop_front();
                if (resp_rdata !== e.data || resp_err !== e.err || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL resp%0d got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                             e.id, resp_rdata, resp_err, cyc, e.data, e.err, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one request for one cycle; called and returns at a negedge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_%0d got=%b expected=1", id_ctr, req_ready);
        end else begin
            e.data = exp_d;
            e.err  = exp_e;
            e.cyc  = cyc + LAT;
            e.id   = id_ctr;
            q.push_back(e);
        end
        id_ctr++;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        check("drain_empty", q.size(), 0);
    endtask

    // Called at the negedge where reset is released.
    task automatic wait_clear(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 4 * DEPTH) begin
            n++;
            @(negedge clk);
        end
        check(name, n, DEPTH);
        check({name, "_init_done"}, init_done, 1);
    endtask

    initial begin : drv
        int u0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready",  req_ready,  0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err",   resp_err,   0);
        check("rst_init_done",  init_done,  0);
        reset = 1'b0;
        wait_clear("clear_cycles");

        // Every word reads back zero, back-to-back stream
        for (int i = 0; i < DEPTH; i++) issue(0, 2'b10, 0, 32'(i * 4), 0, 32'h0, 0);
        drain();

        // Byte store into a word, sized loads
        issue(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h11, 32'h123456AA, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h11AA3344, 0);
        issue(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFAA, 0);
        issue(0, 2'b00, 1, 32'h11, 0, 32'h000000AA, 0);
        issue(0, 2'b00, 1, 32'h10, 0, 32'h00000011, 0);
        issue(0, 2'b00, 0, 32'h13, 0, 32'h00000044, 0);
        issue(0, 2'b01, 0, 32'h10, 0, 32'h000011AA, 0);
        issue(0, 2'b01, 1, 32'h12, 0, 32'h00003344, 0);
        drain();

        // Halfword stores and sign/zero extension
        issue(1, 2'b01, 0, 32'h22, 32'hDEAD8001, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h22, 0, 32'hFFFF8001, 0);
        issue(0, 2'b01, 1, 32'h22, 0, 32'h00008001, 0);
        issue(0, 2'b10, 0, 32'h20, 0, 32'h00008001, 0);
        issue(1, 2'b01, 0, 32'h20, 32'h00007FFE, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h20, 0, 32'h7FFE8001, 0);
        issue(0, 2'b01, 0, 32'h20, 0, 32'h00007FFE, 0);
        drain();

        // Error cases, then readback shows nothing was written
        issue(1, 2'b10, 0, 32'h06, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, 2'b01, 0, 32'h03, 0, 32'h0, 1);
        issue(0, 2'b10, 0, 32'(DEPTH * 4), 0, 32'h0, 1);
        issue(1, 2'b00, 0, 32'(DEPTH * 4), 32'h77, 32'h0, 1);
        issue(0, 2'b11, 0, 32'h10, 0, 32'h0, 1);
        issue(0, 2'b00, 1, 32'(DEPTH * 4 - 1), 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h04, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h00, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h11AA3344, 0);
        drain();

        // Store at T then load of same word at T+1
        issue(1, 2'b10, 0, 32'h30, 32'hA5A55A5A, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h30, 0, 32'hA5A55A5A, 0);
        issue(1, 2'b10, 0, 32'h3C, 32'hCAFEF00D, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h3F, 0, 32'h0000000D, 0);
        drain();

        // Reset in the middle of CLEAR restarts the full walk
        reset = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clear("clear_restart");

        // Reset with two loads in flight drops their responses
        issue(1, 2'b10, 0, 32'h3C, 32'hCAFEF00D, 32'h0, 0);
        drain();
        u0 = unexpected;
        issue(0, 2'b10, 0, 32'h3C, 0, 32'hCAFEF00D, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h0, 0);
        reset = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clear("clear_after_inflight");
        check("no_resp_after_reset", unexpected - u0, 0);

        // Memory is zero again after the clear
        issue(0, 2'b10, 0, 32'h3C, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h30, 0, 32'h0, 0);
        drain();

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d expected completion", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised successor to the single-port data memory.
- Supports byte, halfword and word loads and stores, with sign/zero extension on loads.
- Detects misaligned and out-of-range accesses, uses a valid/ready request handshake and a configurable read-response latency.
- Clears itself to zero after reset; sits between the datapath's memory stage and the rest of the core.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; must be ≥2.
- ADDR_W, 32, request address width.
- READ_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, taken from the low bits: [7:0] byte, [15:0] half, [31:0] word.
- resp_valid  output  1  response strobe, one per accepted request.
- resp_rdata  output  32  load result; 0 for stores and for errors.
- resp_err  output  1  misaligned access, out-of-range access or reserved size.
- init_done  output  1  high once the post-reset clear has completed.

Behaviour:
- Reset values: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, init_done = 0. All pipeline valid bits are cleared.
- Reset is synchronous and active-high.
- State machine:
  - CLEAR: entered on reset. A counter walks word indices 0..DEPTH_WORDS-1, writing 0 to one word per cycle. req_ready = 0.
  - Transition CLEAR→RUN occurs on the cycle after index DEPTH_WORDS-1 is written. Clearing therefore takes exactly DEPTH_WORDS cycles after reset deasserts.
  - RUN: req_ready = 1 and init_done = 1.
  - Reset asserted in either state returns to CLEAR with the counter at 0 and drops in-flight responses.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. The block is fully pipelined; one request can be accepted per cycle.
- Address decode:
  - Word index is req_addr[ADDR_W-1:2]; byte offset is req_addr[1:0].
  - Out-of-range: word index ≥ DEPTH_WORDS.
  - Misaligned: half with offset[0] = 1, or word with offset ≠ 00.
- Byte lane order (fixed): byte offset 0 maps to bits [31:24], offset 3 to [7:0]. Half offset 0 maps to [31:16], offset 2 to [15:0].
- Stores:
  - A legal store updates only the addressed lanes at the acceptance edge; other lanes keep their value.
  - An erroring store writes nothing.
  - A response is still produced with rdata = 0 and err reflecting the check.
- Loads:
  - The array is read at the acceptance edge, returning contents prior to any write at that same edge.
  - The selected lanes are right-justified, then sign- or zero-extended to 32 bits.
  - An erroring load returns rdata = 0 and err = 1.
- Latency:
  - resp_valid, resp_rdata and resp_err appear exactly READ_LATENCY cycles after the acceptance edge.
  - They are pipelined through a READ_LATENCY-deep shift register of {valid, err, data}.
  - Responses are in order; there is no response backpressure.
- Store-then-load ordering: a store accepted at edge T followed by a load to the same word accepted at T+1 returns the new data. No forwarding is needed, since one request per edge cannot collide.
- With req_valid low, or during CLEAR, no pipeline entry becomes valid.

Decomposition:
- Package dmem_pkg:
  - size_t enum: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11.
  - FSM state enum: CLEAR, RUN.
  - Constant MAX_READ_LATENCY = 4.
- Sub-module dmem_lane_align (combinational):
  - Store lane-mask and merge-data generation.
  - Load lane extract with sign/zero extension.
  - Misalign detect.
- The top level holds the array, the clear FSM/counter and the response pipeline.

Test Plan:
1. Reset for 2 cycles, release -> req_ready and init_done stay 0 for exactly DEPTH_WORDS cycles, then rise to 1. A word load from every index returns 0x00000000 with err = 0.
2. Store word 0x11223344 at addr 0x10. Store byte 0xAA at 0x11. Load word at 0x10 -> 0x11AA3344. Load signed byte at 0x11 -> 0xFFFFFFAA. Load unsigned byte -> 0x000000AA.
3. Store half 0x8001 at 0x22. Load signed half at 0x22 -> 0xFFFF8001. Load unsigned half -> 0x00008001. Word at 0x20 keeps lanes [31:16].
4. Word store at 0x06, half load at 0x03, and word load at DEPTH_WORDS*4 -> resp_err = 1 and rdata = 0 for each. Memory is unchanged on readback.
5. With READ_LATENCY = 3, issue a back-to-back load stream on 5 consecutive cycles -> 5 consecutive resp_valid pulses starting 3 cycles after the first acceptance, in order. Store at T then load of the same word at T+1 -> new data.
6. Assert reset mid-CLEAR and again with 2 loads in flight -> no resp_valid after reset. Clearing restarts from index 0 and takes the full DEPTH_WORDS cycles.
